// File: rtl/i2s_pkg.sv
// Shared types for the I2S playback path: FSM states and the stereo sample word.
package i2s_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Packed so that a 64-bit FIFO word maps directly: [63:32] right, [31:0] left.
  typedef struct packed {
    logic [SAMPLE_W-1:0] right;
    logic [SAMPLE_W-1:0] left;
  } sample_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
// A rise sampled at edge k appears at rise output after edge k+STAGES-1, so it acts on edge k+STAGES.
module i2s_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clock_bridge_0_out_clk_clk,
  input  logic hps_0_h2f_reset_reset_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              last_q, last_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    last_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clock_bridge_0_out_clk_clk or negedge hps_0_h2f_reset_reset_n) begin
    if (!hps_0_h2f_reset_reset_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  // Edge taken between the final synchronizer stage and its one-cycle-old copy.
  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/i2s_playback_prefetch.sv
// Two-entry prefetch buffer between the playback FIFO and the I2S shifter, popped by synchronized shift_ack edges.
// Refills on the same cycle a pop frees a slot; stalls on fifo_empty and counts underruns (saturating).
module i2s_playback_prefetch
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int UNDERRUN_W  = 16
) (
  input  logic                  clock_bridge_0_out_clk_clk,
  input  logic                  hps_0_h2f_reset_reset_n,
  input  logic                  dma_enable,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic                  shift_ack,
  output logic [SAMPLE_W-1:0]   out_left,
  output logic [SAMPLE_W-1:0]   out_right,
  output logic                  out_valid,
  output logic [1:0]            buf_level,
  input  logic                  underrun_clr,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  state_e                state_q, state_d;
  logic [1:0]            level_q, level_d;
  sample_t               head_q, head_d;
  sample_t               pf_q, pf_d;
  logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;

  logic    ack_rise;
  logic    pop;
  logic    fetch;
  logic    underrun_evt;
  sample_t fifo_word;

  assign fifo_word = fifo_data;

  i2s_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clock_bridge_0_out_clk_clk(clock_bridge_0_out_clk_clk),
    .hps_0_h2f_reset_reset_n   (hps_0_h2f_reset_reset_n),
    .async_in                  (shift_ack),
    .rise                      (ack_rise)
  );

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    head_d       = head_q;
    pf_d         = pf_q;
    ucnt_d       = ucnt_q;
    pop          = ack_rise && (state_q == RUN) && (level_q != 2'd0);
    fetch        = (state_q != IDLE) && dma_enable && !fifo_empty &&
                   ((level_q < 2'd2) || pop);
    underrun_evt = (pop && (level_q == 2'd1) && !fetch) ||
                   (ack_rise && (state_q == PRIME));

    if (!dma_enable) begin
      state_d = IDLE;
      level_d = 2'd0;
    end else begin
      // New word always lands in the first free slot after any promotion.
      case ({pop, fetch})
        2'b10: begin
          head_d  = pf_q;
          level_d = level_q - 2'd1;
        end
        2'b01: begin
          if (level_q == 2'd0) head_d = fifo_word;
          else                 pf_d   = fifo_word;
          level_d = level_q + 2'd1;
        end
        2'b11: begin
          if (level_q == 2'd1) begin
            head_d = fifo_word;
          end else begin
            head_d = pf_q;
            pf_d   = fifo_word;
          end
        end
        default: ;
      endcase

      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (level_d == 2'd2) state_d = RUN;
        RUN:     if (pop && (level_d == 2'd0)) state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end

    if (underrun_clr) begin
      ucnt_d = '0;
    end else if (underrun_evt && !(&ucnt_q)) begin
      ucnt_d = ucnt_q + {{(UNDERRUN_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock_bridge_0_out_clk_clk or negedge hps_0_h2f_reset_reset_n) begin
    if (!hps_0_h2f_reset_reset_n) begin
      state_q <= IDLE;
      level_q <= 2'd0;
      head_q  <= '0;
      pf_q    <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      head_q  <= head_d;
      pf_q    <= pf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign fifo_read      = fetch;
  assign out_left       = head_q.left;
  assign out_right      = head_q.right;
  assign out_valid      = (state_q == RUN) && (level_q != 2'd0);
  assign buf_level      = level_q;
  assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_i2s_playback_prefetch.sv
// Scoreboarded bench: FIFO model feeds the DUT, every word read is expected to be presented in order.
module tb_i2s_playback_prefetch;

  localparam int S = 3;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dma_enable = 1'b0;
  logic [63:0]   fifo_data = 64'd0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read;
  logic          shift_ack = 1'b0;
  logic [31:0]   out_left, out_right;
  logic          out_valid;
  logic [1:0]    buf_level;
  logic          underrun_clr = 1'b0;
  logic [W-1:0]  underrun_count;

  i2s_playback_prefetch #(
    .SYNC_STAGES(S),
    .UNDERRUN_W (W)
  ) dut (
    .clock_bridge_0_out_clk_clk(clk),
    .hps_0_h2f_reset_reset_n   (rst_n),
    .dma_enable                (dma_enable),
    .fifo_data                 (fifo_data),
    .fifo_empty                (fifo_empty),
    .fifo_read                 (fifo_read),
    .shift_ack                 (shift_ack),
    .out_left                  (out_left),
    .out_right                 (out_right),
    .out_valid                 (out_valid),
    .buf_level                 (buf_level),
    .underrun_clr              (underrun_clr),
    .underrun_count            (underrun_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          rd_total = 0;
  int          pres_total = 0;
  logic [63:0] fifo_q[$];
  logic [63:0] exp_q[$];
  bit          rd_pend = 1'b0;
  bit          prev_valid = 1'b0;
  logic [63:0] prev_dat = 64'd0;
  logic [63:0] exp_word;

  localparam logic [63:0] A = 64'h11112222_33334444;
  localparam logic [63:0] B = 64'hAAAA5555_0F0F1234;
  localparam logic [63:0] C = 64'hC0C0C0C0_13572468;
  localparam logic [63:0] D = 64'hDDDD0001_DDDD0002;
  localparam logic [63:0] E = 64'hEEEE0001_EEEE0002;
  localparam logic [63:0] F = 64'hF00DF00D_BEEFBEEF;
  localparam logic [63:0] G = 64'h9999AAAA_BBBBCCCC;
  localparam logic [63:0] H = 64'h12345678_9ABCDEF0;
  localparam logic [63:0] I = 64'h0BADC0DE_DEADBEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts reads, pushes the word being read, compares each newly presented sample.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_read) begin
        rd_total++;
        rd_pend = 1'b1;
        if (fifo_q.size() > 0) exp_q.push_back(fifo_q[0]);
        else chk("read_while_empty", 64'd1, 64'd0);
      end
      if (out_valid && (!prev_valid || {out_right, out_left} != prev_dat)) begin
        pres_total++;
        if (exp_q.size() == 0) begin
          chk("present_unexpected", {out_right, out_left}, 64'd0);
        end else begin
          exp_word = exp_q.pop_front();
          chk("present_order", {out_right, out_left}, exp_word);
        end
      end
      prev_valid = out_valid;
      prev_dat   = {out_right, out_left};
    end else begin
      prev_valid = 1'b0;
    end
  end

  // FIFO model: retire the read word after the capturing edge, then refresh the head.
  always begin
    @(posedge clk);
    #1;
    if (rd_pend) begin
      void'(fifo_q.pop_front());
      rd_pend = 1'b0;
    end
    #1;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 64'd0 : fifo_q[0];
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    shift_ack = 1'b1;
    wait_clk(2);
    shift_ack = 1'b0;
    wait_clk(2);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      wait_clk(1);
      n++;
    end
    chk(name, 64'(out_valid), 64'd1);
  endtask

  int r0;
  int ack_hold;

  initial begin
    // Reset state
    wait_clk(3);
    #3;
    chk("rst_fifo_read", 64'(fifo_read), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_left", 64'(out_left), 64'd0);
    chk("rst_out_right", 64'(out_right), 64'd0);
    chk("rst_buf_level", 64'(buf_level), 64'd0);
    chk("rst_underrun", 64'(underrun_count), 64'd0);
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(2);

    // Prime with A then B
    fifo_q.push_back(A);
    fifo_q.push_back(B);
    dma_enable = 1'b1;
    wait_clk(1);
    @(negedge clk);
    chk("prime_rd1", 64'(fifo_read), 64'd1);
    @(negedge clk);
    chk("prime_rd2", 64'(fifo_read), 64'd1);
    wait_clk(1);
    chk("prime_valid", 64'(out_valid), 64'd1);
    chk("prime_left", 64'(out_left), 64'h33334444);
    chk("prime_right", 64'(out_right), 64'h11112222);
    chk("prime_level", 64'(buf_level), 64'd2);

    // Pop with refill: outputs change exactly SYNC_STAGES edges after the edge following the rise
    fifo_q.push_back(C);
    wait_clk(1);
    r0 = rd_total;
    shift_ack = 1'b1;
    for (int i = 1; i <= S; i++) begin
      wait_clk(1);
      chk("pop_hold_left", 64'(out_left), 64'(A[31:0]));
    end
    wait_clk(1);
    chk("pop_new_left", 64'(out_left), 64'(B[31:0]));
    chk("pop_new_right", 64'(out_right), 64'(B[63:32]));
    chk("pop_level", 64'(buf_level), 64'd2);
    shift_ack = 1'b0;
    wait_clk(3);
    chk("pop_one_read", 64'(rd_total - r0), 64'd1);

    // Underrun with FIFO empty
    ack_pulse();
    chk("ur_level1", 64'(buf_level), 64'd1);
    chk("ur_left_c", 64'(out_left), 64'(C[31:0]));
    ack_pulse();
    chk("ur_level0", 64'(buf_level), 64'd0);
    chk("ur_valid0", 64'(out_valid), 64'd0);
    chk("ur_count1", 64'(underrun_count), 64'd1);
    ack_pulse();
    chk("ur_count2", 64'(underrun_count), 64'd2);

    // Saturation at 4 bits, then clear colliding with an increment
    repeat (18) ack_pulse();
    chk("sat_count", 64'(underrun_count), 64'hF);
    shift_ack = 1'b1;
    wait_clk(2);
    shift_ack = 1'b0;
    wait_clk(1);
    underrun_clr = 1'b1;
    wait_clk(1);
    underrun_clr = 1'b0;
    chk("clr_wins", 64'(underrun_count), 64'd0);
    wait_clk(2);
    ack_pulse();
    chk("count_after_clr", 64'(underrun_count), 64'd1);

    // Disable mid-stream
    fifo_q.push_back(D);
    fifo_q.push_back(E);
    wait_valid("dis_prime_valid");
    chk("dis_head_d", 64'(out_left), 64'(D[31:0]));
    chk("dis_level2", 64'(buf_level), 64'd2);
    fifo_q.push_back(F);
    wait_clk(1);
    dma_enable = 1'b0;
    r0 = rd_total;
    wait_clk(1);
    exp_q.delete();
    chk("dis_level0", 64'(buf_level), 64'd0);
    chk("dis_valid0", 64'(out_valid), 64'd0);
    ack_pulse();
    wait_clk(3);
    chk("dis_no_read", 64'(rd_total - r0), 64'd0);
    chk("idle_ack_ignored", 64'(underrun_count), 64'd1);
    fifo_q.push_back(G);
    dma_enable = 1'b1;
    wait_valid("reen_valid");
    chk("reen_head_f", 64'(out_left), 64'(F[31:0]));
    wait_clk(6);
    chk("reen_no_stale_pop", 64'(out_left), 64'(F[31:0]));
    chk("reen_count", 64'(underrun_count), 64'd1);

    // Async reset in the middle of a pop+fetch cycle
    fifo_q.push_back(H);
    wait_clk(1);
    shift_ack = 1'b1;
    wait_clk(2);
    shift_ack = 1'b0;
    wait_clk(1);
    @(negedge clk);
    chk("pf_read", 64'(fifo_read), 64'd1);
    #1;
    rst_n = 1'b0;
    dma_enable = 1'b0;
    rd_pend = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_fifo_read", 64'(fifo_read), 64'd0);
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_left", 64'(out_left), 64'd0);
    chk("arst_right", 64'(out_right), 64'd0);
    chk("arst_level", 64'(buf_level), 64'd0);
    chk("arst_count", 64'(underrun_count), 64'd0);
    wait_clk(2);
    rst_n = 1'b1;
    r0 = rd_total;
    wait_clk(5);
    chk("post_rst_no_read", 64'(rd_total - r0), 64'd0);
    fifo_q.push_back(I);
    dma_enable = 1'b1;
    wait_valid("post_rst_valid");
    chk("post_rst_head_h", 64'(out_left), 64'(H[31:0]));

    // Randomized traffic: ordering is checked by the monitor
    ack_hold = 2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 8)
        fifo_q.push_back({$urandom, $urandom});
      if (ack_hold == 0) begin
        shift_ack = ~shift_ack;
        ack_hold  = $urandom_range(2, 6);
      end else begin
        ack_hold--;
      end
      if ($urandom_range(0, 199) == 0) begin
        dma_enable = 1'b0;
        wait_clk(1);
        exp_q.delete();
        wait_clk($urandom_range(1, 4));
        dma_enable = 1'b1;
      end
      wait_clk(1);
    end
    chk("random_presented_some", 64'(pres_total > 40), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached, bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
